// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-multiplier error evaluation harnesses.
// Holds the FSM state encoding, statistic width margins and the absolute-difference helper.
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eval_state_t;

  // Extra bits on top of the operand widths so error and sum registers never wrap.
  localparam int ERR_EXTRA_W = 1;
  localparam int SUM_EXTRA_W = 1;

  function automatic int err_width(input int out_w);
    return out_w + ERR_EXTRA_W;
  endfunction

  function automatic int sum_width(input int in_w, input int out_w);
    return in_w + out_w + SUM_EXTRA_W;
  endfunction

  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/exact_mul_ref.sv
// Combinational unsigned A*B reference multiplier shared by the evaluation harnesses.
// The product is full width, so it never truncates.
module exact_mul_ref #(
  parameter int A_W = 2
) (
  input  logic [A_W-1:0]   a,
  input  logic [A_W-1:0]   b,
  output logic [2*A_W-1:0] product
);

  assign product = (2*A_W)'(a) * (2*A_W)'(b);

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Sweeps every input vector through an approximate multiplier netlist and accumulates
// max/sum/violation error statistics against the exact product.
module approx_mul_err_monitor
  import approx_eval_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 4,
  parameter int ET      = 5,
  parameter int DUT_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IN_W-1:0]       cand_in,
  input  logic [OUT_W-1:0]      cand_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [OUT_W:0]        max_err,
  output logic [IN_W-1:0]       worst_vec,
  output logic [IN_W+OUT_W:0]   sum_err,
  output logic [IN_W:0]         viol_cnt
);

  localparam int A_W   = IN_W / 2;
  localparam int ERR_W = err_width(OUT_W);
  localparam int SUM_W = sum_width(IN_W, OUT_W);
  localparam int CNT_W = IN_W + 1;

  localparam logic [IN_W-1:0]  LAST_VEC = '1;
  localparam logic [ERR_W-1:0] ET_V     = ERR_W'(ET);

  eval_state_t state, next_state;

  logic             start_ok;
  logic             drv_valid;
  logic             tail_valid;
  logic [IN_W-1:0]  tail_vec;
  logic             line0_last;

  logic             cap_valid;
  logic [IN_W-1:0]  cap_vec;
  logic [OUT_W-1:0] cap_out;
  logic [IN_W-1:0]  exact;
  logic [ERR_W-1:0] err;
  logic             final_cmp;

  logic [ERR_W-1:0] max_next;
  logic [IN_W-1:0]  worst_next;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] viol_next;

  assign start_ok = start && ((state == IDLE) || (state == DONE));

  // Delay line matches the netlist latency so each capture pairs a vector with its own result.
  if (DUT_LAT == 0) begin : g_no_line
    assign tail_valid = drv_valid;
    assign tail_vec   = cand_in;
    assign line0_last = 1'b0;
  end else begin : g_line
    logic [DUT_LAT-1:0] dl_valid;
    logic [IN_W-1:0]    dl_vec [DUT_LAT];

    always_ff @(posedge clk) begin
      if (rst || start_ok) begin
        dl_valid <= '0;
        for (int k = 0; k < DUT_LAT; k++) dl_vec[k] <= '0;
      end else begin
        dl_valid[0] <= drv_valid;
        dl_vec[0]   <= cand_in;
        for (int k = 1; k < DUT_LAT; k++) begin
          dl_valid[k] <= dl_valid[k-1];
          dl_vec[k]   <= dl_vec[k-1];
        end
      end
    end

    assign tail_valid = dl_valid[DUT_LAT-1];
    assign tail_vec   = dl_vec[DUT_LAT-1];
    assign line0_last = dl_valid[0] && (dl_vec[0] == LAST_VEC);
  end

  exact_mul_ref #(.A_W(A_W)) u_exact (
    .a       (cap_vec[A_W-1:0]),
    .b       (cap_vec[IN_W-1:A_W]),
    .product (exact)
  );

  assign err       = ERR_W'(abs_diff(32'(exact), 32'(cap_out)));
  assign final_cmp = cap_valid && (cap_vec == LAST_VEC);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // DRAIN covers the netlist latency after the last vector has left the driver.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SWEEP;
      SWEEP:   if (final_cmp) next_state = DONE;
               else if (line0_last) next_state = DRAIN;
      DRAIN:   if (final_cmp) next_state = DONE;
      DONE:    if (start) next_state = SWEEP;
      default: next_state = IDLE;
    endcase
  end

  // Strict max update keeps the lowest vector on ties.
  always_comb begin
    max_next   = max_err;
    worst_next = worst_vec;
    sum_next   = sum_err;
    viol_next  = viol_cnt;
    if (cap_valid) begin
      sum_next = sum_err + SUM_W'(err);
      if (err > max_err) begin
        max_next   = err;
        worst_next = cap_vec;
      end
      if (err > ET_V) viol_next = viol_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_in   <= '0;
      drv_valid <= 1'b0;
      cap_valid <= 1'b0;
      cap_vec   <= '0;
      cap_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_err   <= '0;
      worst_vec <= '0;
      sum_err   <= '0;
      viol_cnt  <= '0;
    end else begin
      busy <= (next_state == SWEEP) || (next_state == DRAIN);
      done <= (next_state == DONE);
      pass <= (next_state == DONE) && (max_next <= ET_V);
      if (start_ok) begin
        cand_in   <= '0;
        drv_valid <= 1'b1;
        cap_valid <= 1'b0;
        cap_vec   <= '0;
        cap_out   <= '0;
        max_err   <= '0;
        worst_vec <= '0;
        sum_err   <= '0;
        viol_cnt  <= '0;
      end else begin
        if (drv_valid) begin
          if (cand_in == LAST_VEC) drv_valid <= 1'b0;
          else                     cand_in   <= cand_in + 1'b1;
        end
        cap_valid <= tail_valid;
        cap_vec   <= tail_vec;
        cap_out   <= cand_out;
        max_err   <= max_next;
        worst_vec <= worst_next;
        sum_err   <= sum_next;
        viol_cnt  <= viol_next;
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Self-checking bench: models the approximate netlist (exact, constant, random LUT, pipelined)
// and compares harness statistics against an arithmetic reference sweep.
module tb_approx_mul_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [3:0] cand_in, cand_out, worst_vec;
  logic       busy, done, pass;
  logic [4:0] max_err, viol_cnt;
  logic [8:0] sum_err;

  logic [3:0] cand_in_l2, cand_out_l2, worst_vec_l2;
  logic       busy_l2, done_l2, pass_l2;
  logic [4:0] max_err_l2, viol_cnt_l2;
  logic [8:0] sum_err_l2;

  logic [3:0] cand_in_l1, cand_out_l1, worst_vec_l1;
  logic       busy_l1, done_l1, pass_l1;
  logic [4:0] max_err_l1, viol_cnt_l1;
  logic [8:0] sum_err_l1;

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = 0;
  logic [3:0] lut [16];

  approx_mul_err_monitor #(.IN_W(4), .OUT_W(4), .ET(5), .DUT_LAT(0)) dut (
    .clk(clk), .rst(rst), .start(start), .cand_in(cand_in), .cand_out(cand_out),
    .busy(busy), .done(done), .pass(pass), .max_err(max_err), .worst_vec(worst_vec),
    .sum_err(sum_err), .viol_cnt(viol_cnt)
  );

  approx_mul_err_monitor #(.IN_W(4), .OUT_W(4), .ET(5), .DUT_LAT(2)) dut_l2 (
    .clk(clk), .rst(rst), .start(start), .cand_in(cand_in_l2), .cand_out(cand_out_l2),
    .busy(busy_l2), .done(done_l2), .pass(pass_l2), .max_err(max_err_l2), .worst_vec(worst_vec_l2),
    .sum_err(sum_err_l2), .viol_cnt(viol_cnt_l2)
  );

  approx_mul_err_monitor #(.IN_W(4), .OUT_W(4), .ET(5), .DUT_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .start(start), .cand_in(cand_in_l1), .cand_out(cand_out_l1),
    .busy(busy_l1), .done(done_l1), .pass(pass_l1), .max_err(max_err_l1), .worst_vec(worst_vec_l1),
    .sum_err(sum_err_l1), .viol_cnt(viol_cnt_l1)
  );

  function automatic int prod(input int v);
    return (v % 4) * (v / 4);
  endfunction

  function automatic int approx_of(input int m, input int v);
    case (m)
      0:       return prod(v);
      1:       return 0;
      2:       return 15;
      default: return int'(lut[v]);
    endcase
  endfunction

  always_comb cand_out = 4'(approx_of(mode, int'(cand_in)));

  // Exact multiplier behind two registers, for the latency instances.
  logic [3:0] l2_r1 = '0, l2_r2 = '0, l1_r1 = '0, l1_r2 = '0;
  always @(posedge clk) begin
    l2_r1 <= 4'(prod(int'(cand_in_l2)));
    l2_r2 <= l2_r1;
    l1_r1 <= 4'(prod(int'(cand_in_l1)));
    l1_r2 <= l1_r1;
  end
  assign cand_out_l2 = l2_r2;
  assign cand_out_l1 = l1_r2;

  task automatic ref_stats(input int m, output int emax, output int ewv,
                           output int esum, output int eviol);
    int e;
    emax = 0; ewv = 0; esum = 0; eviol = 0;
    for (int v = 0; v < 16; v++) begin
      e = prod(v) - approx_of(m, v);
      if (e < 0) e = -e;
      esum += e;
      if (e > emax) begin emax = e; ewv = v; end
      if (e > 5) eviol++;
    end
  endtask

  task automatic run_sweep(input int pulse_at, output int cyc);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    while (!done && cyc < 60) begin
      start = (cyc + 1 == pulse_at);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, pass}); end
    n_checks++; if (cand_in !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_cand_in: got %0d expected 0", cand_in); end
    n_checks++; if ({max_err, worst_vec, sum_err, viol_cnt} !== 23'd0) begin n_fail++; $display("[TB] FAIL reset_stats: got %h expected 0", {max_err, worst_vec, sum_err, viol_cnt}); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_duts();
    int cyc;
    int exp_max [3] = '{0, 9, 15};
    int exp_wv  [3] = '{0, 15, 0};
    int exp_sum [3] = '{0, 36, 204};
    int exp_vio [3] = '{0, 3, 16};
    for (int m = 0; m < 3; m++) begin
      mode = m;
      run_sweep(-1, cyc);
      n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL fixed%0d_latency: got %0d expected 17", m, cyc); end
      n_checks++; if (int'(max_err) !== exp_max[m]) begin n_fail++; $display("[TB] FAIL fixed%0d_max: got %0d expected %0d", m, max_err, exp_max[m]); end
      n_checks++; if (int'(worst_vec) !== exp_wv[m]) begin n_fail++; $display("[TB] FAIL fixed%0d_worst: got %0d expected %0d", m, worst_vec, exp_wv[m]); end
      n_checks++; if (int'(sum_err) !== exp_sum[m]) begin n_fail++; $display("[TB] FAIL fixed%0d_sum: got %0d expected %0d", m, sum_err, exp_sum[m]); end
      n_checks++; if (int'(viol_cnt) !== exp_vio[m]) begin n_fail++; $display("[TB] FAIL fixed%0d_viol: got %0d expected %0d", m, viol_cnt, exp_vio[m]); end
      n_checks++; if (pass !== (m == 0)) begin n_fail++; $display("[TB] FAIL fixed%0d_pass: got %0b expected %0b", m, pass, m == 0); end
    end
  endtask

  task automatic test_random_luts();
    int cyc, emax, ewv, esum, eviol;
    for (int it = 0; it < 4; it++) begin
      for (int v = 0; v < 16; v++)
        lut[v] = (it == 0) ? 4'(prod(v) + ((v % 3) == 0 ? 1 : 0)) : 4'($urandom_range(0, 15));
      mode = 3;
      ref_stats(3, emax, ewv, esum, eviol);
      run_sweep(-1, cyc);
      n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL rand%0d_latency: got %0d expected 17", it, cyc); end
      n_checks++; if (int'(max_err) !== emax) begin n_fail++; $display("[TB] FAIL rand%0d_max: got %0d expected %0d", it, max_err, emax); end
      n_checks++; if (int'(worst_vec) !== ewv) begin n_fail++; $display("[TB] FAIL rand%0d_worst: got %0d expected %0d", it, worst_vec, ewv); end
      n_checks++; if (int'(sum_err) !== esum) begin n_fail++; $display("[TB] FAIL rand%0d_sum: got %0d expected %0d", it, sum_err, esum); end
      n_checks++; if (int'(viol_cnt) !== eviol) begin n_fail++; $display("[TB] FAIL rand%0d_viol: got %0d expected %0d", it, viol_cnt, eviol); end
      n_checks++; if (pass !== (emax <= 5)) begin n_fail++; $display("[TB] FAIL rand%0d_pass: got %0b expected %0b", it, pass, emax <= 5); end
    end
  endtask

  task automatic test_latency();
    int cyc, c0, c1, c2;
    mode = 0;
    repeat (5) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    cyc = 0; c0 = -1; c1 = -1; c2 = -1;
    while (cyc < 40 && (c1 < 0 || c2 < 0)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done && c0 < 0) c0 = cyc;
      if (done_l1 && c1 < 0) c1 = cyc;
      if (done_l2 && c2 < 0) c2 = cyc;
    end
    n_checks++; if (c0 !== 17) begin n_fail++; $display("[TB] FAIL lat0_done: got %0d expected 17", c0); end
    n_checks++; if (c2 !== 19) begin n_fail++; $display("[TB] FAIL lat2_done: got %0d expected 19", c2); end
    n_checks++; if ({max_err_l2, sum_err_l2, viol_cnt_l2} !== 19'd0) begin n_fail++; $display("[TB] FAIL lat2_stats: got %h expected 0", {max_err_l2, sum_err_l2, viol_cnt_l2}); end
    n_checks++; if (pass_l2 !== 1'b1) begin n_fail++; $display("[TB] FAIL lat2_pass: got %0b expected 1", pass_l2); end
    n_checks++; if (c1 !== 18) begin n_fail++; $display("[TB] FAIL lat1_done: got %0d expected 18", c1); end
    n_checks++; if (sum_err_l1 == 9'd0) begin n_fail++; $display("[TB] FAIL lat1_sum: got 0 expected nonzero"); end
  endtask

  task automatic test_reset_midsweep();
    int cyc;
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (cand_in !== 4'd7 && cyc < 30) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cand_in !== 4'd7) begin n_fail++; $display("[TB] FAIL abort_reach7: got %0d expected 7", cand_in); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("[TB] FAIL abort_flags: got %b expected 000", {busy, done, pass}); end
    n_checks++; if (cand_in !== 4'd0) begin n_fail++; $display("[TB] FAIL abort_cand_in: got %0d expected 0", cand_in); end
    n_checks++; if ({max_err, worst_vec, sum_err, viol_cnt} !== 23'd0) begin n_fail++; $display("[TB] FAIL abort_stats: got %h expected 0", {max_err, worst_vec, sum_err, viol_cnt}); end
    rst = 1'b0;
    mode = 0;
    run_sweep(-1, cyc);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL abort_rerun_latency: got %0d expected 17", cyc); end
    n_checks++; if ({max_err, sum_err, viol_cnt, pass} !== 20'd1) begin n_fail++; $display("[TB] FAIL abort_rerun_stats: got %h expected 1", {max_err, sum_err, viol_cnt, pass}); end
  endtask

  task automatic test_back_to_back();
    int cyc, emax, ewv, esum, eviol;
    for (int v = 0; v < 16; v++) lut[v] = 4'($urandom_range(0, 15));
    mode = 3;
    ref_stats(3, emax, ewv, esum, eviol);
    run_sweep(5, cyc);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL b2b_ignore_latency: got %0d expected 17", cyc); end
    n_checks++; if (int'(sum_err) !== esum || int'(max_err) !== emax) begin n_fail++; $display("[TB] FAIL b2b_ignore_stats: got sum %0d max %0d expected sum %0d max %0d", sum_err, max_err, esum, emax); end
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    n_checks++; if ({done, busy, pass} !== 3'b010) begin n_fail++; $display("[TB] FAIL b2b_restart_flags: got %b expected 010", {done, busy, pass}); end
    n_checks++; if ({cand_in, max_err, sum_err, viol_cnt} !== 23'd0) begin n_fail++; $display("[TB] FAIL b2b_restart_clear: got %h expected 0", {cand_in, max_err, sum_err, viol_cnt}); end
    cyc = 0;
    while (!done && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL b2b_restart_latency: got %0d expected 17", cyc); end
    n_checks++; if (int'(worst_vec) !== ewv || int'(viol_cnt) !== eviol) begin n_fail++; $display("[TB] FAIL b2b_restart_stats: got wv %0d viol %0d expected wv %0d viol %0d", worst_vec, viol_cnt, ewv, eviol); end
    run_sweep(17, cyc);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("[TB] FAIL collide_latency: got %0d expected 17", cyc); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({done, busy} !== 2'b10 || int'(sum_err) !== esum) begin n_fail++; $display("[TB] FAIL collide_hold: got done/busy %b sum %0d expected 10 sum %0d", {done, busy}, sum_err, esum); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_fixed_duts();
    test_random_luts();
    test_latency();
    test_reset_midsweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
